// File: rtl/nf10_axis_pkt_checker.sv
`default_nettype none
// ============================================================================
// nf10_axis_pkt_checker : AXI4-Stream sink that checks reference packets
//                         (2 header beats + payload) and counts good/bad ones.
// Revision 1.0
// ============================================================================
module nf10_axis_pkt_checker #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 64,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [63:0] C_HDR_WORD_0         = 64'hEFBEFECAFECAFECA,
  parameter logic [63:0] C_HDR_WORD_1         = 64'h00000008EFBEEFBE,
  parameter int          C_PAYLOAD_WORDS      = 32,
  parameter logic [7:0]  C_READY_PATTERN      = 8'hFF
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              clear,
  output logic [31:0]                       pkt_good_count,
  output logic [31:0]                       pkt_err_count,
  output logic                              err_flag,
  output logic [2:0]                        last_err_code,
  output logic                              busy
);

  typedef enum logic [1:0] {
    HDR0  = 2'd0,
    HDR1  = 2'd1,
    PAY   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] LAST_WC = 8'(C_PAYLOAD_WORDS - 1);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_HDR     = 3'd1;
  localparam logic [2:0] ERR_PAY     = 3'd2;
  localparam logic [2:0] ERR_STRB    = 3'd3;
  localparam logic [2:0] ERR_EARLY   = 3'd4;
  localparam logic [2:0] ERR_MISSING = 3'd5;

  state_t     state;
  logic [7:0] wc;
  logic [7:0] pat;

  logic        beat;
  logic        is_last_wc;
  logic        strb_bad;
  logic        data_bad;
  logic        last_bad;
  logic [63:0] exp_word;
  logic [2:0]  beat_code;
  logic        good_evt;
  logic        err_evt;

  logic unused_tuser;
  assign unused_tuser = ^s_axis_tuser;

  // Per-beat classification; priority is strobe, then data, then tlast.
  always_comb begin
    beat       = s_axis_tvalid && s_axis_tready;
    is_last_wc = (wc == LAST_WC);
    strb_bad   = (s_axis_tstrb != '1);
    case (state)
      HDR0:    exp_word = C_HDR_WORD_0;
      HDR1:    exp_word = C_HDR_WORD_1;
      default: exp_word = {8{wc}};
    endcase
    data_bad = (s_axis_tdata != exp_word);
    last_bad = ((state == PAY) && is_last_wc) ? !s_axis_tlast : s_axis_tlast;
    if (strb_bad)
      beat_code = ERR_STRB;
    else if (data_bad)
      beat_code = (state == PAY) ? ERR_PAY : ERR_HDR;
    else if (last_bad)
      beat_code = s_axis_tlast ? ERR_EARLY : ERR_MISSING;
    else
      beat_code = ERR_NONE;
    good_evt = beat && (state == PAY) && is_last_wc && (beat_code == ERR_NONE);
    err_evt  = beat && (state != DRAIN) && (beat_code != ERR_NONE);
  end

  // Packet FSM; busy is registered alongside the state it reflects.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state <= HDR0;
      wc    <= 8'd0;
      busy  <= 1'b0;
    end else if (beat) begin
      if (state == DRAIN) begin
        if (s_axis_tlast) begin
          state <= HDR0;
          wc    <= 8'd0;
          busy  <= 1'b0;
        end
      end else if (beat_code != ERR_NONE) begin
        // A missing-tlast beat never carries tlast, so it always drains.
        if (s_axis_tlast) begin
          state <= HDR0;
          wc    <= 8'd0;
          busy  <= 1'b0;
        end else begin
          state <= DRAIN;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          HDR0: begin
            state <= HDR1;
            busy  <= 1'b1;
          end
          HDR1: begin
            state <= PAY;
          end
          PAY: begin
            if (is_last_wc) begin
              state <= HDR0;
              wc    <= 8'd0;
              busy  <= 1'b0;
            end else begin
              wc <= wc + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Statistics; clear takes precedence over any same-cycle update.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pkt_good_count <= 32'd0;
      pkt_err_count  <= 32'd0;
      err_flag       <= 1'b0;
      last_err_code  <= ERR_NONE;
    end else if (clear) begin
      pkt_good_count <= 32'd0;
      pkt_err_count  <= 32'd0;
      err_flag       <= 1'b0;
      last_err_code  <= ERR_NONE;
    end else begin
      if (good_evt && (pkt_good_count != 32'hFFFF_FFFF))
        pkt_good_count <= pkt_good_count + 32'd1;
      if (err_evt) begin
        if (pkt_err_count != 32'hFFFF_FFFF)
          pkt_err_count <= pkt_err_count + 32'd1;
        err_flag      <= 1'b1;
        last_err_code <= beat_code;
      end
    end
  end

  // Rotating back-pressure pattern drives a registered tready.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pat           <= C_READY_PATTERN;
      s_axis_tready <= 1'b0;
    end else begin
      pat           <= {pat[0], pat[7:1]};
      s_axis_tready <= pat[0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nf10_axis_pkt_checker.sv
`default_nettype none
// ============================================================================
// tb_nf10_axis_pkt_checker : randomized packet traffic against a packet-level
//                            reference model, plus directed literal checks.
// Revision 1.0
// ============================================================================
module tb_nf10_axis_pkt_checker;

  localparam logic [63:0] H0  = 64'hEFBEFECAFECAFECA;
  localparam logic [63:0] H1  = 64'h00000008EFBEEFBE;
  localparam int          PW  = 32;
  localparam int          TOT = PW + 2;
  localparam logic [7:0]  PAT = 8'hA5;

  logic         clk = 1'b0;
  logic         axi_resetn = 1'b0;
  logic [63:0]  s_axis_tdata = 64'd0;
  logic [7:0]   s_axis_tstrb = 8'hFF;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         clear = 1'b0;
  logic         s_axis_tready;
  logic [31:0]  pkt_good_count;
  logic [31:0]  pkt_err_count;
  logic         err_flag;
  logic [2:0]   last_err_code;
  logic         busy;

  int checks = 0;
  int failures = 0;
  bit rand_clear_en = 0;
  logic [7:0] pat_v = PAT;
  bit rdy_lit [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  always #5 clk = ~clk;

  nf10_axis_pkt_checker #(
    .C_S_AXIS_DATA_WIDTH (64),
    .C_S_AXIS_TUSER_WIDTH(128),
    .C_HDR_WORD_0        (H0),
    .C_HDR_WORD_1        (H1),
    .C_PAYLOAD_WORDS     (PW),
    .C_READY_PATTERN     (PAT)
  ) dut (
    .axi_aclk      (clk),
    .axi_resetn    (axi_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .clear         (clear),
    .pkt_good_count(pkt_good_count),
    .pkt_err_count (pkt_err_count),
    .err_flag      (err_flag),
    .last_err_code (last_err_code),
    .busy          (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference beat b of a packet: two header words, then {8{k}} for payload word k.
  function automatic logic [63:0] ref_word(input int b);
    logic [7:0] k;
    if (b == 0) return H0;
    if (b == 1) return H1;
    k = 8'(b - 2);
    return {8{k}};
  endfunction

  // ---------------- packet-level reference model ----------------
  int          m_n;
  logic [31:0] m_good, m_err;
  logic        m_flag;
  logic [2:0]  m_code;
  int          m_beat;
  bit          m_drop;
  int          mc;

  function automatic logic exp_rdy();
    return (m_n == 0) ? 1'b0 : pat_v[(m_n - 1) % 8];
  endfunction

  always @(posedge clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      m_n = 0; m_good = 0; m_err = 0; m_flag = 0; m_code = 0; m_beat = 0; m_drop = 0;
    end else begin
      if (s_axis_tvalid && exp_rdy()) begin
        if (m_drop) begin
          if (s_axis_tlast) begin m_drop = 0; m_beat = 0; end
        end else begin
          if (s_axis_tstrb != 8'hFF)                          mc = 3;
          else if (s_axis_tdata != ref_word(m_beat))          mc = (m_beat < 2) ? 1 : 2;
          else if (s_axis_tlast && m_beat != TOT - 1)         mc = 4;
          else if (!s_axis_tlast && m_beat == TOT - 1)        mc = 5;
          else                                                mc = 0;
          if (mc != 0) begin
            if (m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
            m_flag = 1; m_code = 3'(mc);
            if (s_axis_tlast) m_beat = 0; else m_drop = 1;
          end else if (m_beat == TOT - 1) begin
            if (m_good != 32'hFFFF_FFFF) m_good = m_good + 1;
            m_beat = 0;
          end else begin
            m_beat = m_beat + 1;
          end
        end
      end
      if (clear) begin m_good = 0; m_err = 0; m_flag = 0; m_code = 0; end
      m_n = m_n + 1;
    end
  end

  always @(negedge clk) begin
    chk("tready", 32'(s_axis_tready), 32'(exp_rdy()));
    chk("good_count", pkt_good_count, m_good);
    chk("err_count", pkt_err_count, m_err);
    chk("err_flag", 32'(err_flag), 32'(m_flag));
    chk("err_code", 32'(last_err_code), 32'(m_code));
    chk("busy", 32'(busy), 32'(m_drop || (m_beat != 0)));
  end

  // ---------------- stimulus ----------------
  function automatic logic rclr();
    return rand_clear_en && ($urandom_range(0, 149) == 0);
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] st, input logic l, input logic clr);
    int  gap;
    bit  acc;
    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    repeat (gap) begin
      s_axis_tvalid = 0; s_axis_tdata = {$urandom, $urandom}; s_axis_tlast = $urandom_range(0, 1) == 1;
      clear = rclr();
      @(negedge clk);
    end
    s_axis_tvalid = 1; s_axis_tdata = d; s_axis_tstrb = st; s_axis_tlast = l;
    s_axis_tuser = {4{$urandom}};
    clear = clr | rclr();
    for (int w = 0; ; w++) begin
      acc = s_axis_tready;
      @(negedge clk);
      if (acc) break;
      if (w > 64) begin
        checks++; failures++;
        $display("FAIL beat_timeout: got no tready expected accept within 64 cycles at %0t", $time);
        break;
      end
      clear = clr | rclr();
    end
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tstrb = 8'hFF; clear = 0;
  endtask

  task automatic pulse_reset();
    s_axis_tvalid = 0; clear = 0;
    #2 axi_resetn = 0;
    @(negedge clk);
    #2 axi_resetn = 1;
    @(negedge clk);
  endtask

  // kind: 0 none, 1 bit flip, 2 bad strobe, 3 replace data with ov
  task automatic send_packet(input int len, input int eb, input int kind, input int rst_at,
                             input logic [63:0] ov);
    logic [63:0] d;
    logic [7:0]  st;
    int          bit_i;
    for (int b = 0; b < len; b++) begin
      if (b == rst_at) pulse_reset();
      d  = (b < TOT) ? ref_word(b) : {$urandom, $urandom};
      st = 8'hFF;
      if (b == eb && kind == 1) begin bit_i = int'($urandom_range(0, 63)); d[bit_i] = ~d[bit_i]; end
      if (b == eb && kind == 2) st = 8'($urandom_range(0, 254));
      if (b == eb && kind == 3) d = ov;
      send_beat(d, st, b == len - 1, 1'b0);
    end
  endtask

  initial begin
    int t, len, eb, kind, rst_at;
    @(negedge clk);
    chk("rst_good", pkt_good_count, 32'd0);
    chk("rst_err", pkt_err_count, 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 axi_resetn = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("rdy_seq", 32'(s_axis_tready), 32'(rdy_lit[i]));
      @(negedge clk);
    end

    send_packet(TOT, -1, 0, -1, 64'd0);
    chk("t1_good", pkt_good_count, 32'd1);
    chk("t1_err", pkt_err_count, 32'd0);
    chk("t1_model_good", m_good, 32'd1);

    send_packet(TOT, 7, 3, -1, 64'h0505050505050504);
    chk("t3_err", pkt_err_count, 32'd1);
    chk("t3_code", 32'(last_err_code), 32'd2);
    chk("t3_flag", 32'(err_flag), 32'd1);
    chk("t3_busy_after_tlast", 32'(busy), 32'd0);
    send_packet(TOT, -1, 0, -1, 64'd0);
    chk("t3_good", pkt_good_count, 32'd2);

    send_packet(TOT - 1, -1, 0, -1, 64'd0);
    chk("t4_err", pkt_err_count, 32'd2);
    chk("t4_code", 32'(last_err_code), 32'd4);
    chk("t4_busy", 32'(busy), 32'd0);
    send_packet(TOT, -1, 0, -1, 64'd0);
    chk("t4_good", pkt_good_count, 32'd3);

    for (int b = 0; b < TOT; b++) send_beat(ref_word(b), 8'hFF, 1'b0, 1'b0);
    chk("t5_code", 32'(last_err_code), 32'd5);
    chk("t5_err", pkt_err_count, 32'd3);
    chk("t5_busy_drain", 32'(busy), 32'd1);
    send_beat(64'd1, 8'hFF, 1'b0, 1'b0);
    send_beat(64'd2, 8'hFF, 1'b0, 1'b0);
    chk("t5_still_drain", 32'(busy), 32'd1);
    chk("t5_err_once", pkt_err_count, 32'd3);
    send_beat(64'd3, 8'hFF, 1'b1, 1'b0);
    chk("t5_idle", 32'(busy), 32'd0);
    send_packet(TOT, -1, 0, -1, 64'd0);
    chk("t5_good", pkt_good_count, 32'd4);

    for (int b = 0; b < 10; b++) send_beat(ref_word(b), 8'hFF, 1'b0, 1'b0);
    pulse_reset();
    chk("t6_rst_good", pkt_good_count, 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_flag", 32'(err_flag), 32'd0);
    for (int b = 10; b < TOT; b++) send_beat(ref_word(b), 8'hFF, b == TOT - 1, 1'b0);
    chk("t6_partial_err", pkt_err_count, 32'd1);
    chk("t6_partial_code", 32'(last_err_code), 32'd1);
    send_beat(64'h1234, 8'hFF, 1'b0, 1'b1);
    chk("t6_clr_err", pkt_err_count, 32'd0);
    chk("t6_clr_flag", 32'(err_flag), 32'd0);
    chk("t6_clr_code", 32'(last_err_code), 32'd0);
    chk("t6_fsm_drain", 32'(busy), 32'd1);
    send_beat(64'h5678, 8'hFF, 1'b1, 1'b0);
    send_packet(TOT, -1, 0, -1, 64'd0);
    chk("t6_good", pkt_good_count, 32'd1);

    rand_clear_en = 1;
    for (int p = 0; p < 120; p++) begin
      t = int'($urandom_range(0, 7));
      len = TOT; eb = -1; kind = 0;
      case (t)
        3: begin kind = 1; eb = int'($urandom_range(0, TOT - 1)); end
        4: begin kind = 2; eb = int'($urandom_range(0, TOT - 1)); end
        5: len = int'($urandom_range(1, TOT - 1));
        6: len = TOT + int'($urandom_range(1, 4));
        7: begin
          len  = int'($urandom_range(1, TOT + 3));
          kind = int'($urandom_range(0, 2));
          eb   = int'($urandom_range(0, len - 1));
        end
        default: ;
      endcase
      rst_at = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      send_packet(len, eb, kind, rst_at, 64'd0);
    end
    rand_clear_en = 0;
    send_packet(TOT, -1, 0, -1, 64'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
